// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, data MSB-first, odd parity, stop; line idles high.
module uart_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_BITS    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 data_tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int          IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [15:0]          r_clk_cnt, w_clk_cnt_nxt;
    logic [IDX_W-1:0]     r_bit_idx, w_bit_idx_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_parity, w_parity_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 r_done, w_done_nxt;
    logic                 w_last;
    logic                 w_accept;

    assign w_last   = (r_clk_cnt == LAST_CNT);
    assign tx_ready = (r_state == S_IDLE) || ((r_state == S_STOP) && w_last);
    assign w_accept = tx_valid && tx_ready;
    assign data_tx  = r_tx;
    assign tx_busy  = (r_state != S_IDLE);
    assign tx_done  = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_parity  <= w_parity_nxt;
            r_tx      <= w_tx_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // data_tx is registered, so each branch loads the value of the bit being entered.
    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = w_last ? 16'd0 : r_clk_cnt + 16'd1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_parity_nxt  = r_parity;
        w_tx_nxt      = r_tx;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clk_cnt_nxt = 16'd0;
                w_tx_nxt      = 1'b1;
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = tx_data;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                w_parity_nxt = ~^r_shift;
                if (w_last) begin
                    w_state_nxt   = S_DATA;
                    w_bit_idx_nxt = IDX_W'(DATA_BITS - 1);
                    w_tx_nxt      = r_shift[DATA_BITS-1];
                    w_shift_nxt   = r_shift << 1;
                end
            end
            S_DATA: begin
                if (w_last) begin
                    if (r_bit_idx == '0) begin
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = r_parity;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx - IDX_W'(1);
                        w_tx_nxt      = r_shift[DATA_BITS-1];
                        w_shift_nxt   = r_shift << 1;
                    end
                end
            end
            S_PARITY: begin
                if (w_last) begin
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_last) begin
                    w_done_nxt = 1'b1;
                    if (w_accept) begin
                        w_state_nxt = S_START;
                        w_shift_nxt = tx_data;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_clk_cnt_nxt = 16'd0;
                w_tx_nxt      = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx at default and CLKS_PER_BIT=4.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [5:0] tx_data = '0;
    logic       tx_ready, data_tx, tx_busy, tx_done;
    logic       v4 = 1'b0;
    logic [5:0] d4 = '0;
    logic       rdy4, tx4, busy4, done4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_tx dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .data_tx(data_tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .tx_valid(v4), .tx_data(d4),
        .tx_ready(rdy4), .data_tx(tx4), .tx_busy(busy4), .tx_done(done4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic [17:0] e;
        int          cnt;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_state", 32'({data_tx, tx_busy, tx_done}), 32'b100);
        rst = 1'b0;

        // 1: idle for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle", 32'({data_tx, tx_ready, tx_busy, tx_done}), 32'b1100);
        end

        // 2: single frame 101101, parity 1
        tx_valid = 1'b1; tx_data = 6'b101101;
        e = 18'b0_101101_1_1_000000000;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            check($sformatf("f2_bit%0d", i), 32'(data_tx), 32'(e[17-i]));
            check($sformatf("f2_done%0d", i), 32'(tx_done), 32'd0);
        end
        check("f2_ready_last_stop", 32'(tx_ready), 32'd1);
        @(negedge clk);
        check("f2_done", 32'({tx_done, tx_busy, data_tx}), 32'b101);
        @(negedge clk);
        check("f2_done_off", 32'(tx_done), 32'd0);

        // 3: back-to-back 000000 then 000001 with valid held
        tx_valid = 1'b1; tx_data = 6'b000000;
        e = 18'b0_000000_1_1_0_000001_0_1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            tx_data = 6'b000001;
            check($sformatf("b2b_bit%0d", i), 32'(data_tx), 32'(e[17-i]));
            if (i == 7) check("b2b_ready7", 32'(tx_ready), 32'd0);
            if (i == 8) check("b2b_ready8", 32'(tx_ready), 32'd1);
            if (i == 9) begin
                check("b2b_done_mid", 32'({tx_done, tx_busy}), 32'b11);
                tx_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_done_end", 32'({tx_done, tx_busy, data_tx}), 32'b101);

        // 4: valid pulse while busy is ignored; frame 010010, parity 1
        @(negedge clk);
        tx_valid = 1'b1; tx_data = 6'b010010;
        e = 18'b0_010010_1_1_000000000;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            tx_valid = (i == 3);
            tx_data  = (i == 3) ? 6'b111111 : 6'b000000;
            if (i < 9) check($sformatf("busy_bit%0d", i), 32'(data_tx), 32'(e[17-i]));
            if (tx_done) cnt++;
        end
        tx_valid = 1'b0;
        check("busy_done_count", 32'(cnt), 32'd1);
        check("busy_idle_after", 32'({data_tx, tx_busy}), 32'b10);

        // 5: reset during data bit index 3 of 100110
        tx_valid = 1'b1; tx_data = 6'b100110;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tx_valid = 1'b0;
        end
        check("rst_pre_d3", 32'(data_tx), 32'd0);
        #1 rst = 1'b1;
        #1 check("rst_async", 32'({data_tx, tx_busy, tx_ready}), 32'b101);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx_done) cnt++;
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (tx_done) cnt++;
        end
        check("rst_no_done", 32'(cnt), 32'd0);
        tx_valid = 1'b1; tx_data = 6'b100110;
        e = 18'b0_100110_0_1_000000000;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            check($sformatf("rst_clean_bit%0d", i), 32'(data_tx), 32'(e[17-i]));
        end
        @(negedge clk);
        check("rst_clean_done", 32'(tx_done), 32'd1);

        // 6: CLKS_PER_BIT=4, data 110000, parity 1
        v4 = 1'b1; d4 = 6'b110000;
        e = 18'b0_110000_1_1_000000000;
        cnt = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            v4 = 1'b0;
            check($sformatf("slow_bit%0d", i), 32'(tx4), 32'(e[17-(i/4)]));
            if (rdy4) cnt++;
            if (i == 35) check("slow_ready_last", 32'(rdy4), 32'd1);
        end
        check("slow_ready_count", 32'(cnt), 32'd1);
        @(negedge clk);
        check("slow_done", 32'({done4, busy4, tx4}), 32'b101);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
